// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle RV32I sequencer (master) and its datapath (slave).
// The master reads instruction fields and ALU/memory status, and drives every datapath control.
interface multicycle_control_fsm_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       sign;
  logic       mem_ready;
  logic       mem_req;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       halted;
  logic [1:0] trap_cause;

  modport master (
    input  opcode, funct3, funct7b5, zero, sign, mem_ready,
    output mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, halted, trap_cause
  );

  modport slave (
    output opcode, funct3, funct7b5, zero, sign, mem_ready,
    input  mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, halted, trap_cause
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Moore sequencer for the multicycle RV32I core: one shared ALU, one unified memory.
// Optional PERF_CNT_EN adds free-running cycle and retired-instruction counters.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_FETCH    | read instruction at PC, PC <= PC+4 when memory answers
// S_DECODE   | branch target into ALUOut, dispatch on opcode
// S_MEMADR   | effective address RegA + imm
// S_MEMREAD  | load access at ALUOut
// S_MEMWB    | write ReadData to rd
// S_MEMWRITE | store access at ALUOut
// S_EXECR    | register-register ALU op
// S_EXECI    | register-immediate ALU op
// S_ALUWB    | write ALUOut to rd
// S_JAL      | PC <= OldPC + imm, ALU computes OldPC + 4 for rd
// S_BRANCH   | compare via sub, conditionally load PC from ALUOut
// S_TRAP     | halted, all controls quiet until reset
module multicycle_control_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 32
) (
  input  logic clk,
  input  logic rst,
  multicycle_control_fsm_if.master bus
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_CYCLES);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  if (CNT_W == 0) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BRANCH, S_TRAP
  } state_t;

  state_t        state;
  logic [TW-1:0] to_cnt;
  logic [1:0]    cause_q;
  logic          retire;
  logic          waiting;
  logic          timeout_hit;

  function automatic logic [1:0] imm_dec(input logic [6:0] op);
    case (op)
      OP_SW:   return 2'b01;
      OP_B:    return 2'b10;
      OP_JAL:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic f7b5,
                                         input logic is_r);
    case (f3)
      3'b000:  return (is_r && f7b5) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  always_comb begin
    bus.mem_req    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.PCWrite    = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ResultSrc  = 2'b00;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.ImmSrc     = imm_dec(bus.opcode);
    bus.ALUControl = 3'b000;
    bus.halted     = 1'b0;
    bus.trap_cause = cause_q;
    retire         = 1'b0;
    case (state)
      S_FETCH: begin
        bus.mem_req   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.IRWrite   = bus.mem_ready;
        bus.PCWrite   = bus.mem_ready;
      end
      S_DECODE: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        bus.mem_req = 1'b1;
        bus.AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegWrite  = 1'b1;
        retire        = 1'b1;
      end
      S_MEMWRITE: begin
        bus.mem_req  = 1'b1;
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = 1'b1;
        retire       = bus.mem_ready;
      end
      S_EXECR: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUControl = alu_dec(bus.funct3, bus.funct7b5, 1'b1);
      end
      S_EXECI: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUSrcB    = 2'b01;
        bus.ALUControl = alu_dec(bus.funct3, bus.funct7b5, 1'b0);
      end
      S_ALUWB: begin
        bus.RegWrite = 1'b1;
        retire       = 1'b1;
      end
      S_JAL: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        bus.PCWrite = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUControl = 3'b001;
        retire         = 1'b1;
        case (bus.funct3)
          3'b000:  bus.PCWrite = bus.zero;
          3'b001:  bus.PCWrite = ~bus.zero;
          3'b100:  bus.PCWrite = bus.sign;
          default: bus.PCWrite = 1'b0;
        endcase
      end
      S_TRAP: begin
        bus.ImmSrc = 2'b00;
        bus.halted = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      bus.mem_req    = 1'b0;
      bus.AdrSrc     = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.IRWrite    = 1'b0;
      bus.PCWrite    = 1'b0;
      bus.RegWrite   = 1'b0;
      bus.ResultSrc  = 2'b00;
      bus.ALUSrcA    = 2'b00;
      bus.ALUSrcB    = 2'b00;
      bus.ImmSrc     = 2'b00;
      bus.ALUControl = 3'b000;
      bus.halted     = 1'b0;
      bus.trap_cause = 2'b00;
      retire         = 1'b0;
    end
  end

  // A ready in the limit cycle completes the access, so the limit only bites on an unanswered cycle.
  assign waiting     = bus.mem_req && !bus.mem_ready;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && waiting && (to_cnt == TO_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      to_cnt  <= '0;
      cause_q <= 2'b00;
    end else begin
      if (TIMEOUT_CYCLES == 0 || timeout_hit || !waiting) to_cnt <= '0;
      else                                                to_cnt <= to_cnt + TW'(1);

      if (timeout_hit) begin
        state   <= S_TRAP;
        cause_q <= 2'b10;
      end else begin
        case (state)
          S_FETCH:    if (bus.mem_ready) state <= S_DECODE;
          S_DECODE: begin
            case (bus.opcode)
              OP_LW, OP_SW: state <= S_MEMADR;
              OP_R:         state <= S_EXECR;
              OP_I:         state <= S_EXECI;
              OP_B:         state <= S_BRANCH;
              OP_JAL:       state <= S_JAL;
              default: begin
                state   <= S_TRAP;
                cause_q <= 2'b01;
              end
            endcase
          end
          S_MEMADR:   state <= bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
          S_MEMREAD:  if (bus.mem_ready) state <= S_MEMWB;
          S_MEMWB:    state <= S_FETCH;
          S_MEMWRITE: if (bus.mem_ready) state <= S_FETCH;
          S_EXECR:    state <= S_ALUWB;
          S_EXECI:    state <= S_ALUWB;
          S_ALUWB:    state <= S_FETCH;
          S_JAL:      state <= S_ALUWB;
          S_BRANCH:   state <= S_FETCH;
          S_TRAP:     state <= S_TRAP;
          default:    state <= S_FETCH;
        endcase
      end
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] ret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (state != S_TRAP) cyc_q <= cyc_q + CNT_W'(1);
      if (retire)          ret_q <= ret_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = rst ? '0 : cyc_q;
  assign instret_cnt = rst ? '0 : ret_q;
`endif

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Sequencing controller for the multicycle RV32I core variant, which shares one ALU and one unified instruction/data memory across cycles.
- A Moore FSM that decodes opcode, funct3 and funct7[5] and drives every datapath mux, register-file and memory enable.
- Handles memory wait states through a req/ready handshake.
- Halts with a trap cause on an illegal opcode or a memory timeout.

Parameters:
TIMEOUT_CYCLES, 255, number of cycles mem_req may stay high without mem_ready before a bus-timeout trap; 0 disables the timeout
CNT_W, 32, width of the optional performance counters

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
opcode  in  7  instr[6:0] from the instruction register
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
zero  in  1  ALU result == 0
sign  in  1  ALU result[31]
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
AdrSrc  out  1  0 = PC, 1 = ALUOut as the memory address
MemWrite  out  1  store strobe
IRWrite  out  1  load the instruction register and OldPC
PCWrite  out  1  load PC from the result mux
RegWrite  out  1  register-file write enable
ResultSrc  out  2  00 = ALUOut, 01 = ReadData, 10 = ALUResult
ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = RegA
ALUSrcB  out  2  00 = RegB, 01 = ImmExt, 10 = constant 4
ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
ALUControl  out  3  000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt
halted  out  1  FSM is in TRAP
trap_cause  out  2  00 = none, 01 = illegal opcode, 10 = bus timeout; sticky until rst

Behaviour:
- Reset (synchronous, rst=1):
  - state <= FETCH; timeout counter <= 0; trap_cause <= 00.
  - While rst=1, all outputs are forced to 0.
  - Reset mid-access abandons the access; the next cycle starts a fresh FETCH.
- Outputs are combinational from the state; any signal not listed for a state is 0. ImmSrc is always decoded from opcode: lw/I-ALU → 00, sw → 01, branch → 10, jal → 11, others → 00.
- FETCH:
  - Drives mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - On mem_ready: IRWrite=1 and PCWrite=1 in that same cycle, then → DECODE. Otherwise stay in FETCH.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (computes the branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - any other opcode → TRAP with cause 01
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. → MEMREAD if opcode[5]=0, else → MEMWRITE.
- MEMREAD: mem_req=1, AdrSrc=1. On mem_ready → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, retire. → FETCH.
- MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1 held until mem_ready. On mem_ready: retire, → FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALU decode. → ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALU decode. → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, retire. → FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 (PC <= target). → ALUWB, which writes OldPC+4 to rd.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, retire, → FETCH.
  - PCWrite = zero for funct3 000 (beq), ~zero for 001 (bne), sign for 100 (blt).
  - Any other funct3 gives PCWrite=0: not taken, no trap.
- ALU decode (EXECR/EXECI) by funct3:
  - 000: sub if EXECR and funct7b5=1, else add
  - 010: slt
  - 110: or
  - 111: and
  - any other funct3: add
- Timeout:
  - The counter increments each cycle mem_req=1 && mem_ready=0, and clears on mem_ready or on leaving the state.
  - When the count reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES ≠ 0): → TRAP with cause 10 on the next edge.
  - mem_ready arriving in the same cycle as the limit wins: the access completes, no trap.
- TRAP: all control outputs 0, halted=1, trap_cause held. Exit only via rst.
- Latency in cycles, with zero memory wait states:
  - lw 5
  - sw 4
  - R-type and I-type 4
  - branch 3
  - jal 4

Optional Feature:
PERF_CNT_EN:
- Defined: adds output ports cycle_cnt[CNT_W-1:0] and instret_cnt[CNT_W-1:0], both reset to 0.
  - cycle_cnt increments every non-reset cycle except in TRAP.
  - instret_cnt increments on each retire cycle.
  - Both wrap modulo 2^CNT_W.
- Undefined: the ports are absent and no counter logic is built; all other behaviour is identical.

Test Plan:
1. add x3,x1,x2 (opcode 0110011, funct3 000, funct7b5 0), mem_ready tied 1 → FETCH→DECODE→EXECR→ALUWB; ALUControl=000 in EXECR; RegWrite=1 for exactly one cycle; 4 cycles total.
2. sub variant (funct7b5=1) → ALUControl=001 in EXECR. Same instruction as addi (opcode 0010011, funct7b5=1) → ALUControl=000 in EXECI.
3. lw with mem_ready low 3 cycles in MEMREAD → mem_req and AdrSrc=1 held 4 cycles; MEMWB follows with ResultSrc=01 and RegWrite=1.
4. beq with zero=1 → PCWrite=1 in BRANCH. bne with zero=1 → PCWrite=0. blt with sign=1 → PCWrite=1. funct3 010 → PCWrite=0, no trap.
5. Opcode 1110011 → TRAP after DECODE: halted=1, trap_cause=01, outputs frozen at 0 until rst; rst returns to FETCH with trap_cause=00.
6. TIMEOUT_CYCLES=4 and mem_ready held 0 in FETCH → trap_cause=10 after 4 wait cycles. Repeat with rst asserted during MEMWRITE → next cycle in FETCH, MemWrite=0.
